dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port word-addressed data memory.
- Shares the memory between the core load/store unit (port 0) and a DMA/debug master (port 1).
- Handles byte/halfword stores by read-modify-write.
- Memory keeps its combinational read and posedge write. This block owns all of its address, write-enable and write-data inputs.

---
 rtl/dmem_arbiter_pkg.sv | 31 +++
 rtl/dmem_lane_merge.sv | 33 +++
 rtl/dmem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned NUM_DMEM_PORTS = 2;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } dmem_arb_state_e;

    // Misaligned half/word accesses and the reserved size code are rejected.
    function automatic logic dmem_req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte/half lane insertion for read-modify-write stores and lane extraction for loads.
module dmem_lane_merge
    import dmem_arbiter_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_merged,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_old_word >> {i_addr_lo, 3'b000};
        case (i_size)
            MEM_BYTE: o_load_data = {24'h0, w_shifted[7:0]};
            MEM_HALF: o_load_data = {16'h0, w_shifted[15:0]};
            default:  o_load_data = w_shifted;
        endcase
    end

    always_comb begin
        o_merged = i_old_word;
        case (i_size)
            MEM_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            MEM_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default:  o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory, with sub-word RMW stores.
// Define DMEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 6,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic [NUM_DMEM_PORTS-1:0]                     i_req_valid,
    output logic [NUM_DMEM_PORTS-1:0]                     o_req_ready,
    input  logic [NUM_DMEM_PORTS-1:0]                     i_req_we,
    input  logic [NUM_DMEM_PORTS-1:0][1:0]                i_req_size,
    input  logic [NUM_DMEM_PORTS-1:0][ADDRESS_WIDTH+1:0]  i_req_addr,
    input  logic [NUM_DMEM_PORTS-1:0][DATA_WIDTH-1:0]     i_req_wdata,
    output logic [NUM_DMEM_PORTS-1:0]                     o_rsp_valid,
    output logic                                          o_rsp_err,
    output logic [DATA_WIDTH-1:0]                         o_rsp_rdata,
    output logic                                          o_mem_write_en,
    output logic [ADDRESS_WIDTH+1:0]                      o_mem_address,
    output logic [DATA_WIDTH-1:0]                         o_mem_write_data,
    input  logic [DATA_WIDTH-1:0]                         i_mem_read_data
);

    dmem_arb_state_e          r_state;
    dmem_arb_state_e          w_state_next;
    logic                     r_port;
    logic                     r_we;
    logic [1:0]               r_size;
    logic [ADDRESS_WIDTH+1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_old_word;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic                  w_grant_port;
    logic                  w_accept;
    logic                  w_req_bad;
    logic [DATA_WIDTH-1:0] w_lane_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_load_data;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_grant_port = i_req_valid[0] ? 1'b0 : 1'b1;
`else
    logic r_rr_ptr;

    assign w_grant_port = (&i_req_valid) ? r_rr_ptr : i_req_valid[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_grant_port;
        end
    end
`endif

    assign w_accept  = (r_state == IDLE) && (|i_req_valid) && i_rst_n;
    assign w_req_bad = dmem_req_bad(i_req_size[w_grant_port], i_req_addr[w_grant_port][1:0]);

    // Loads extract from live read data; MERGE rebuilds from the captured old word.
    assign w_lane_word = (r_state == MERGE) ? r_old_word : i_mem_read_data;

    dmem_lane_merge u_lane_merge (
        .i_old_word  (w_lane_word),
        .i_wdata     (r_wdata),
        .i_size      (r_size),
        .i_addr_lo   (r_addr[1:0]),
        .o_merged    (w_merged),
        .o_load_data (w_load_data)
    );

    always_comb begin
        w_state_next     = r_state;
        o_req_ready      = '0;
        o_rsp_valid      = '0;
        o_rsp_err        = 1'b0;
        o_mem_write_en   = 1'b0;
        o_mem_write_data = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    o_req_ready[w_grant_port] = 1'b1;
                    w_state_next = w_req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (r_we && (r_size == MEM_WORD)) begin
                    o_mem_write_en   = 1'b1;
                    o_mem_write_data = r_wdata;
                    w_state_next     = RESP;
                end else if (r_we) begin
                    w_state_next = MERGE;
                end else begin
                    w_state_next = RESP;
                end
            end
            MERGE: begin
                o_mem_write_en   = 1'b1;
                o_mem_write_data = w_merged;
                w_state_next     = RESP;
            end
            RESP: begin
                o_rsp_valid[r_port] = 1'b1;
                o_rsp_err           = r_err;
                w_state_next        = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // Reset wins immediately so an abandoned MERGE never writes in the reset cycle.
        if (!i_rst_n) begin
            w_state_next     = IDLE;
            o_req_ready      = '0;
            o_rsp_valid      = '0;
            o_rsp_err        = 1'b0;
            o_mem_write_en   = 1'b0;
            o_mem_write_data = '0;
        end
    end

    assign o_mem_address = i_rst_n ? r_addr : '0;
    assign o_rsp_rdata   = i_rst_n ? r_rdata : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_old_word <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port  <= w_grant_port;
                        r_we    <= i_req_we[w_grant_port];
                        r_size  <= i_req_size[w_grant_port];
                        r_addr  <= i_req_addr[w_grant_port];
                        r_wdata <= i_req_wdata[w_grant_port];
                        r_err   <= w_req_bad;
                        if (w_req_bad) begin
                            r_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load_data;
                    end else if (r_size == MEM_WORD) begin
                        r_rdata <= '0;
                    end else begin
                        r_old_word <= i_mem_read_data;
                    end
                end
                MERGE: r_rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural combinational-read memory.
module tb_dmem_arbiter;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          req_valid = '0;
    logic [1:0]          req_ready;
    logic [1:0]          req_we = '0;
    logic [1:0][1:0]     req_size = '0;
    logic [1:0][AW-1:0]  req_addr = '0;
    logic [1:0][31:0]    req_wdata = '0;
    logic [1:0]          rsp_valid;
    logic                rsp_err;
    logic [31:0]         rsp_rdata;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;

    logic [31:0] mem [64] = '{default: 32'h0};
    assign mem_rdata = mem[mem_addr[7:2]];

    dmem_arbiter #(
        .ADDRESS_WIDTH (6),
        .DATA_WIDTH    (32)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_we         (req_we),
        .i_req_size       (req_size),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_err        (rsp_err),
        .o_rsp_rdata      (rsp_rdata),
        .o_mem_write_en   (mem_we),
        .o_mem_address    (mem_addr),
        .o_mem_write_data (mem_wdata),
        .i_mem_read_data  (mem_rdata)
    );

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          ready_cyc;
    } exp_t;

    exp_t        sb[$];
    int          rsp_log[$];
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt             <= wr_cnt + 1;
            last_wr_addr       <= mem_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid != 2'b00) begin
            rsp_log.push_back(cyc);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid);
            end else begin
                e = sb.pop_front();
                check("rsp_port", {30'h0, rsp_valid}, 32'h1 << e.port);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_latency", cyc - e.ready_cyc, e.lat);
            end
        end
    end

    task automatic issue(input int p, input logic we, input logic [1:0] size,
                         input logic [7:0] addr, input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] exp_rd, input int lat, input bit push,
                         output int rdy_cyc);
        int waited = 0;
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_size[p]  = size;
        req_addr[p]  = addr;
        req_wdata[p] = wd;
        #1;
        while (!req_ready[p] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        rdy_cyc = cyc;
        if (!req_ready[p]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: port %0d ready got 0 expected 1", p);
            req_valid[p] = 1'b0;
            return;
        end
        if (push) sb.push_back('{port: p, err: exp_err, rdata: exp_rd, lat: lat, ready_cyc: cyc});
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int rc2;
        int wc0;
        int waited;
        logic [1:0] exp_grant;
        int gport;

        // Reset values, with both ports requesting to show ready stays low.
        req_valid = 2'b11;
        req_size  = {2'b10, 2'b10};
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", {30'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {30'h0, rsp_valid}, 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_mem_we", {31'h0, mem_we}, 32'h0);
        check("reset_mem_addr", {24'h0, mem_addr}, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load.
        wc0 = wr_cnt;
        issue(0, 1'b1, 2'b10, 8'h08, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b1, rc);
        drain();
        check("word_store_writes", wr_cnt - wc0, 1);
        check("word_store_addr", {24'h0, last_wr_addr}, 32'h08);
        check("word_store_mem", mem[2], 32'hDEADBEEF);
        issue(0, 1'b0, 2'b10, 8'h08, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b1, rc);

        // Byte store by read-modify-write.
        wc0 = wr_cnt;
        issue(0, 1'b1, 2'b00, 8'h0A, 32'h000000AA, 1'b0, 32'h0, 3, 1'b1, rc);
        drain();
        check("byte_store_writes", wr_cnt - wc0, 1);
        check("byte_store_mem", mem[2], 32'hDEAABEEF);

        // Sub-word loads and a half store.
        issue(0, 1'b0, 2'b00, 8'h0A, 32'h0, 1'b0, 32'h000000AA, 2, 1'b1, rc);
        issue(0, 1'b0, 2'b01, 8'h08, 32'h0, 1'b0, 32'h0000BEEF, 2, 1'b1, rc);
        issue(0, 1'b0, 2'b01, 8'h0A, 32'h0, 1'b0, 32'h0000DEAA, 2, 1'b1, rc);
        issue(0, 1'b0, 2'b00, 8'h0B, 32'h0, 1'b0, 32'h000000DE, 2, 1'b1, rc);
        issue(0, 1'b1, 2'b01, 8'h0E, 32'hFFFF5566, 1'b0, 32'h0, 3, 1'b1, rc);
        issue(0, 1'b0, 2'b10, 8'h0C, 32'h0, 1'b0, 32'h55660000, 2, 1'b1, rc);
        drain();

        // Error requests: no writes, rdata cleared, one-cycle latency.
        wc0 = wr_cnt;
        issue(0, 1'b1, 2'b01, 8'h05, 32'h00001111, 1'b1, 32'h0, 1, 1'b1, rc);
        issue(0, 1'b0, 2'b10, 8'h06, 32'h0, 1'b1, 32'h0, 1, 1'b1, rc);
        issue(1, 1'b0, 2'b11, 8'h04, 32'h0, 1'b1, 32'h0, 1, 1'b1, rc);
        issue(1, 1'b1, 2'b10, 8'h01, 32'hCAFEF00D, 1'b1, 32'h0, 1, 1'b1, rc);
        drain();
        check("err_no_writes", wr_cnt - wc0, 0);
        check("err_mem1_unchanged", mem[1], 32'h0);
        check("err_mem0_unchanged", mem[0], 32'h0);

        // Port 1 back-to-back store/load.
        rsp_log.delete();
        issue(1, 1'b1, 2'b10, 8'h10, 32'h12345678, 1'b0, 32'h0, 2, 1'b1, rc);
        issue(1, 1'b0, 2'b10, 8'h10, 32'h0, 1'b0, 32'h12345678, 2, 1'b1, rc2);
        drain();
        check("b2b_accept_gap", rc2 - rc, 3);
        if (rsp_log.size() > 0) check("b2b_after_rsp", rc2, rsp_log[0] + 1);
        else check("b2b_rsp_seen", rsp_log.size(), 1);

        // Reset during MERGE of a byte store.
        wc0 = wr_cnt;
        issue(0, 1'b1, 2'b00, 8'h08, 32'h00000077, 1'b0, 32'h0, 3, 1'b0, rc);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("merge_write_en", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_gates_write", {31'h0, mem_we}, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_no_writes", wr_cnt - wc0, 0);
        check("reset_mem_unchanged", mem[2], 32'hDEAABEEF);

        // Both ports requesting continuously after reset release.
        req_we    = 2'b00;
        req_size  = {2'b10, 2'b10};
        req_addr  = {8'h10, 8'h08};
        req_valid = 2'b11;
        rst_n     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            #1;
            while (req_ready == 2'b00 && waited < 10) begin
                @(negedge clk);
                #1;
                waited++;
            end
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gport = 0;
`else
            gport = k % 2;
`endif
            exp_grant = (gport == 0) ? 2'b01 : 2'b10;
            check("grant_order", {30'h0, req_ready}, {30'h0, exp_grant});
            if (req_ready != 2'b00) begin
                sb.push_back('{port: gport, err: 1'b0,
                               rdata: (gport == 0) ? 32'hDEAABEEF : 32'h12345678,
                               lat: 2, ready_cyc: cyc});
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
